// File: rtl/axi_wmem_slave.sv
// AXI4 write-only slave backed by a 32-bit word memory, one burst in flight at a time.
// A registered backdoor port reads any word independently of the AXI write FSM.
module axi_wmem_slave #(
  parameter int unsigned AXI_ID_WIDTH   = 1,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH      = 256
) (
  input  logic                      S_AXI_ACLK,
  input  logic                      S_AXI_ARESET,
  input  logic [AXI_ID_WIDTH-1:0]   S_AXI_AWID,
  input  logic [AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [7:0]                S_AXI_AWLEN,
  input  logic [2:0]                S_AXI_AWSIZE,
  input  logic [1:0]                S_AXI_AWBURST,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [31:0]               S_AXI_WDATA,
  input  logic [3:0]                S_AXI_WSTRB,
  input  logic                      S_AXI_WLAST,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [AXI_ID_WIDTH-1:0]   S_AXI_BID,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr,
  output logic [31:0]               rd_data
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

  state_e                    state_q, state_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [1:0]                burst_q, burst_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic                      nowr_q, nowr_d;
  logic [31:0]               rd_data_q;
  logic [31:0]               mem_q [MEM_DEPTH];

  logic                      aw_hs, w_hs, b_hs;
  logic                      last_beat;
  logic                      wrap_len_ok;
  logic                      aw_bad;
  logic                      mem_we;
  logic [IdxW-1:0]           wr_idx;
  logic [AXI_ADDR_WIDTH-1:0] addr_inc;
  logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
  logic [AXI_ADDR_WIDTH-1:0] addr_next;

  // Handshake readies are gated by reset so they read low for the whole reset window.
  assign S_AXI_AWREADY = ~S_AXI_ARESET & (state_q == StIdle);
  assign S_AXI_WREADY  = ~S_AXI_ARESET & (state_q == StData);
  assign S_AXI_BVALID  = ~S_AXI_ARESET & (state_q == StResp);
  assign S_AXI_BID     = S_AXI_BVALID ? id_q : '0;
  assign S_AXI_BRESP   = {S_AXI_BVALID & err_q, 1'b0};
  assign rd_data       = rd_data_q;

  assign aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID & S_AXI_WREADY;
  assign b_hs      = S_AXI_BVALID & S_AXI_BREADY;
  assign last_beat = (cnt_q == len_q);
  assign mem_we    = w_hs & ~nowr_q;
  assign wr_idx    = addr_q[2 +: IdxW];

  assign wrap_len_ok = (S_AXI_AWLEN == 8'd1) | (S_AXI_AWLEN == 8'd3) |
                       (S_AXI_AWLEN == 8'd7) | (S_AXI_AWLEN == 8'd15);
  assign aw_bad      = (S_AXI_AWSIZE != 3'b010) | (S_AXI_AWBURST == 2'b11) |
                       ((S_AXI_AWBURST == 2'b10) & ~wrap_len_ok);

  // For legal wrap lengths the window is (len+1)*4 bytes, so its offset mask is {len, 2'b11}.
  assign addr_inc  = addr_q + AXI_ADDR_WIDTH'(4);
  assign wrap_mask = AXI_ADDR_WIDTH'({len_q, 2'b11});

  always_comb begin
    addr_next = addr_inc;
    unique case (burst_q)
      2'b00:   addr_next = addr_q;
      2'b10:   addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default: addr_next = addr_inc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    nowr_d  = nowr_q;
    unique case (state_q)
      StIdle: begin
        if (aw_hs) begin
          id_d    = S_AXI_AWID;
          addr_d  = S_AXI_AWADDR;
          len_d   = S_AXI_AWLEN;
          burst_d = S_AXI_AWBURST;
          cnt_d   = 8'd0;
          err_d   = aw_bad;
          nowr_d  = aw_bad;
          state_d = StData;
        end
      end
      StData: begin
        if (w_hs) begin
          cnt_d  = cnt_q + 8'd1;
          addr_d = addr_next;
          if (S_AXI_WLAST != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (b_hs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q <= StIdle;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      nowr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      nowr_q  <= nowr_d;
    end
  end

  // Memory has no reset so contents survive a reset pulse.
  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB[b]) begin
          mem_q[wr_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

endmodule
